// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, centisecond time base, FSM,
// cascaded cs/s/min counters, lap snapshot and registered display outputs.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500_000,
    parameter int PS_W     = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic [6:0] disp_cs,
    output logic [5:0] disp_s,
    output logic [5:0] disp_m,
    output logic [1:0] state,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    state_t cur, nxt;

    logic ss_q, lap_q, clr_q;
    logic ev_ss, ev_lap, ev_clr;
    logic e_ss, e_lap;

    logic [PS_W-1:0] ps;
    logic            run_i;
    logic            tick;
    logic            at_max;

    logic [6:0] live_cs, snap_cs;
    logic [5:0] live_s, snap_s;
    logic [5:0] live_m, snap_m;

    // Rising-edge events; clr outranks ss, ss outranks lap.
    assign ev_ss  = btn_ss  & ~ss_q;
    assign ev_lap = btn_lap & ~lap_q;
    assign ev_clr = btn_clr & ~clr_q;
    assign e_ss   = ev_ss  & ~ev_clr;
    assign e_lap  = ev_lap & ~ev_clr & ~ev_ss;

    assign run_i  = (cur == RUN) || (cur == LAP);
    assign tick   = run_i && (ps == PS_LAST);
    assign at_max = (live_cs == 7'd99) && (live_s == 6'd59) && (live_m == 6'd59);

    assign state   = cur;
    assign running = run_i;

    // Button history; reset to 1 so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q  <= 1'b1;
            lap_q <= 1'b1;
            clr_q <= 1'b1;
        end else begin
            ss_q  <= btn_ss;
            lap_q <= btn_lap;
            clr_q <= btn_clr;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    // Next-state logic; events not listed for a state are ignored.
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (e_ss) nxt = RUN;
            end
            RUN: begin
                if (ev_clr)     nxt = IDLE;
                else if (e_ss)  nxt = PAUSED;
                else if (e_lap) nxt = LAP;
            end
            LAP: begin
                if (ev_clr)     nxt = IDLE;
                else if (e_ss)  nxt = PAUSED;
                else if (e_lap) nxt = RUN;
            end
            PAUSED: begin
                if (ev_clr)     nxt = IDLE;
                else if (e_ss)  nxt = RUN;
            end
            default: nxt = IDLE;
        endcase
    end

    // Prescaler: advances while running, holds in PAUSED so resume keeps the partial tick.
    always_ff @(posedge clk) begin
        if (rst || ev_clr || cur == IDLE) ps <= '0;
        else if (run_i)                   ps <= tick ? '0 : ps + PS_W'(1);
    end

    // Live time cascade; clr wins over a same-cycle tick and suppresses wrap.
    always_ff @(posedge clk) begin
        if (rst || ev_clr) begin
            live_cs <= 7'd0;
            live_s  <= 6'd0;
            live_m  <= 6'd0;
            wrap    <= 1'b0;
        end else begin
            wrap <= tick && at_max;
            if (tick) begin
                if (live_cs == 7'd99) begin
                    live_cs <= 7'd0;
                    if (live_s == 6'd59) begin
                        live_s <= 6'd0;
                        live_m <= (live_m == 6'd59) ? 6'd0 : live_m + 6'd1;
                    end else begin
                        live_s <= live_s + 6'd1;
                    end
                end else begin
                    live_cs <= live_cs + 7'd1;
                end
            end
        end
    end

    // Lap snapshot captures live time as it stood before this cycle's tick.
    always_ff @(posedge clk) begin
        if (rst || ev_clr) begin
            snap_cs <= 7'd0;
            snap_s  <= 6'd0;
            snap_m  <= 6'd0;
        end else if (cur == RUN && e_lap) begin
            snap_cs <= live_cs;
            snap_s  <= live_s;
            snap_m  <= live_m;
        end
    end

    // Display register: frozen snapshot in LAP, live time otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cs <= 7'd0;
            disp_s  <= 6'd0;
            disp_m  <= 6'd0;
        end else if (cur == LAP) begin
            disp_cs <= snap_cs;
            disp_s  <= snap_s;
            disp_m  <= snap_m;
        end else begin
            disp_cs <= live_cs;
            disp_s  <= live_s;
            disp_m  <= live_m;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios plus a random
// button run checked against a time-in-centiseconds reference model.
module tb_stopwatch_ctrl;

    localparam int TD  = 4;
    localparam int DAY = 360000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [6:0] disp_cs;
    logic [5:0] disp_s, disp_m;
    logic [1:0] state;
    logic       running, wrap;

    int checks = 0;
    int failures = 0;

    // reference model state (written only by the model process)
    int m_st, m_ps, m_live, m_snap, m_disp;
    bit m_wrap;
    bit p_ss, p_lap, p_clr;

    // preload request from the bench to the model
    bit pre_req = 1'b0;
    int pre_val = 0;

    stopwatch_ctrl #(.TICK_DIV(TD), .PS_W(3)) dut (
        .clk(clk), .rst(rst),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .disp_cs(disp_cs), .disp_s(disp_s), .disp_m(disp_m),
        .state(state), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: time kept as total centiseconds, states as spec numbers.
    initial begin : ref_model
        bit ec, es, el, run, tk;
        int nst;
        m_st = 0; m_ps = 0; m_live = 0; m_snap = 0; m_disp = 0; m_wrap = 0;
        p_ss = 1; p_lap = 1; p_clr = 1;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st = 0; m_ps = 0; m_live = 0; m_snap = 0; m_disp = 0; m_wrap = 0;
                p_ss = 1; p_lap = 1; p_clr = 1;
            end else begin
                if (pre_req) m_live = pre_val;
                ec  = btn_clr && !p_clr;
                es  = btn_ss  && !p_ss  && !ec;
                el  = btn_lap && !p_lap && !ec && !es;
                run = (m_st == 1) || (m_st == 3);
                tk  = run && (m_ps == TD - 1);
                m_disp = (m_st == 3) ? m_snap : m_live;
                m_wrap = tk && !ec && (m_live == DAY - 1);
                nst = m_st;
                if (ec) nst = 0;
                else if (es) nst = run ? 2 : 1;
                else if (el) begin
                    if (m_st == 1) nst = 3;
                    else if (m_st == 3) nst = 1;
                end
                if (ec) m_snap = 0;
                else if (el && m_st == 1) m_snap = m_live;
                if (ec || m_st == 0) m_ps = 0;
                else if (run) m_ps = tk ? 0 : m_ps + 1;
                if (ec) m_live = 0;
                else if (tk) m_live = (m_live + 1) % DAY;
                m_st = nst;
                p_ss = btn_ss; p_lap = btn_lap; p_clr = btn_clr;
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        btn_clr = 1; clk_n(1);
        btn_clr = 0; clk_n(1);
    endtask

    // b: 0 ss, 1 lap, 2 clr; press lasts one cycle, then one released cycle
    task automatic press(input int b);
        if (b == 0) btn_ss = 1; else if (b == 1) btn_lap = 1; else btn_clr = 1;
        clk_n(1);
        btn_ss = 0; btn_lap = 0; btn_clr = 0;
        clk_n(1);
    endtask

    // Force the live counters while paused; model is told the same value.
    task automatic preload(input int t);
        force dut.live_cs = 7'(t % 100);
        force dut.live_s  = 6'((t / 100) % 60);
        force dut.live_m  = 6'(t / 6000);
        pre_val = t; pre_req = 1;
        @(posedge clk);
        @(negedge clk);
        pre_req = 0;
        release dut.live_cs;
        release dut.live_s;
        release dut.live_m;
    endtask

    task automatic test_reset();
        rst = 1; btn_ss = 1;
        clk_n(3);
        checks++;
        if (state !== 2'd0 || running !== 1'b0 || wrap !== 1'b0 ||
            disp_cs !== 7'd0 || disp_s !== 6'd0 || disp_m !== 6'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d run=%0b wrap=%0b disp=%0d:%0d.%0d required 0,0,0,0:0.0",
                     state, running, wrap, disp_m, disp_s, disp_cs);
        end
        rst = 0;
        clk_n(5);
        checks++;
        if (state !== 2'd0 || disp_cs !== 7'd0) begin
            failures++;
            $display("FAIL held_ss_after_reset: state=%0d cs=%0d required 0 0", state, disp_cs);
        end
        btn_ss = 0; clk_n(1);
        btn_ss = 1; clk_n(1);
        btn_ss = 0;
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL repress_ss: state=%0d required 1", state);
        end
    endtask

    task automatic test_run_pause();
        do_clear();
        btn_ss = 1; clk_n(1);
        btn_ss = 0; clk_n(400);
        checks++;
        if (disp_cs !== 7'd99 || disp_s !== 6'd0) begin
            failures++;
            $display("FAIL run_99cs: disp=%0d.%0d required 0.99", disp_s, disp_cs);
        end
        clk_n(1);
        checks++;
        if (disp_cs !== 7'd0 || disp_s !== 6'd1 || disp_m !== 6'd0 || state !== 2'd1) begin
            failures++;
            $display("FAIL run_1s: disp=%0d:%0d.%0d state=%0d required 0:1.0 state 1",
                     disp_m, disp_s, disp_cs, state);
        end
        btn_ss = 1; clk_n(1);
        btn_ss = 0;
        checks++;
        if (state !== 2'd2 || running !== 1'b0) begin
            failures++;
            $display("FAIL pause: state=%0d running=%0b required 2 0", state, running);
        end
        clk_n(2);
        checks++;
        if (disp_cs !== 7'd0 || disp_s !== 6'd1) begin
            failures++;
            $display("FAIL pause_frozen: disp=%0d.%0d required 1.0", disp_s, disp_cs);
        end
        btn_ss = 1; clk_n(1);
        btn_ss = 0;
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL resume: state=%0d required 1", state);
        end
        clk_n(2);
        checks++;
        if (disp_cs !== 7'd0) begin
            failures++;
            $display("FAIL resume_early: cs=%0d required 0", disp_cs);
        end
        clk_n(1);
        checks++;
        if (disp_cs !== 7'd1 || disp_s !== 6'd1) begin
            failures++;
            $display("FAIL resume_partial_tick: disp=%0d.%0d required 1.1", disp_s, disp_cs);
        end
    endtask

    task automatic test_lap();
        bit found = 0;
        int lv;
        do_clear();
        press(0);
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_live == 37) found = 1;
            else clk_n(1);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL lap_reach_37: live=%0d required 37 within bound", m_live);
            return;
        end
        btn_lap = 1; clk_n(1);
        btn_lap = 0;
        checks++;
        if (state !== 2'd3 || running !== 1'b1) begin
            failures++;
            $display("FAIL lap_enter: state=%0d running=%0b required 3 1", state, running);
        end
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (disp_cs !== 7'd37 || disp_s !== 6'd0 || disp_m !== 6'd0) begin
                failures++;
                $display("FAIL lap_hold: cycle %0d disp=%0d:%0d.%0d required 0:0.37",
                         i, disp_m, disp_s, disp_cs);
            end
            clk_n(1);
        end
        btn_lap = 1; clk_n(1);
        btn_lap = 0;
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL lap_release: state=%0d required 1", state);
        end
        lv = m_live;
        clk_n(1);
        checks++;
        if (disp_cs !== 7'(lv % 100) || disp_s !== 6'((lv / 100) % 60) || disp_cs == 7'd37) begin
            failures++;
            $display("FAIL lap_jump: disp=%0d.%0d required %0d.%0d",
                     disp_s, disp_cs, (lv / 100) % 60, lv % 100);
        end
    endtask

    task automatic test_wrap();
        bit found = 0;
        do_clear();
        press(0);
        press(0);
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL wrap_pause: state=%0d required 2", state);
        end
        preload(DAY - 1);
        checks++;
        if (disp_m !== 6'd59 || disp_s !== 6'd59 || disp_cs !== 7'd99) begin
            failures++;
            $display("FAIL wrap_preload: disp=%0d:%0d.%0d required 59:59.99", disp_m, disp_s, disp_cs);
        end
        btn_ss = 1; clk_n(1);
        btn_ss = 0;
        for (int i = 0; i < 4 * TD && !found; i++) begin
            clk_n(1);
            if (wrap === 1'b1) begin
                found = 1;
                checks++;
                if (disp_m !== 6'd59 || disp_cs !== 7'd99) begin
                    failures++;
                    $display("FAIL wrap_disp_lag: disp=%0d:%0d.%0d required 59:59.99",
                             disp_m, disp_s, disp_cs);
                end
                clk_n(1);
                checks++;
                if (wrap !== 1'b0 || disp_m !== 6'd0 || disp_s !== 6'd0 || disp_cs !== 7'd0) begin
                    failures++;
                    $display("FAIL wrap_after: wrap=%0b disp=%0d:%0d.%0d required 0 0:0.0",
                             wrap, disp_m, disp_s, disp_cs);
                end
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_pulse: wrap never seen, required one pulse");
        end
    endtask

    task automatic test_clr_ss();
        bit found = 0;
        do_clear();
        press(0);
        clk_n(10);
        btn_clr = 1; btn_ss = 1; clk_n(1);
        btn_clr = 0; btn_ss = 0;
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL clr_ss_state: state=%0d required 0", state);
        end
        clk_n(1);
        checks++;
        if (disp_cs !== 7'd0 || disp_s !== 6'd0 || disp_m !== 6'd0) begin
            failures++;
            $display("FAIL clr_ss_disp: disp=%0d:%0d.%0d required 0:0.0", disp_m, disp_s, disp_cs);
        end
        clk_n(3);
        checks++;
        if (state !== 2'd0 || disp_cs !== 7'd0) begin
            failures++;
            $display("FAIL clr_ss_ignored: state=%0d cs=%0d required 0 0", state, disp_cs);
        end
        // clr landing on the wrapping tick
        press(0);
        press(0);
        preload(DAY - 1);
        press(0);
        for (int i = 0; i < 4 * TD && !found; i++) begin
            if (m_st == 1 && m_ps == TD - 1) found = 1;
            else clk_n(1);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL clr_tick_align: no tick cycle within bound");
            return;
        end
        btn_clr = 1; clk_n(1);
        btn_clr = 0;
        checks++;
        if (wrap !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL clr_tick: wrap=%0b state=%0d required 0 0", wrap, state);
        end
        clk_n(1);
        checks++;
        if (wrap !== 1'b0 || disp_m !== 6'd0 || disp_s !== 6'd0 || disp_cs !== 7'd0) begin
            failures++;
            $display("FAIL clr_tick_zero: wrap=%0b disp=%0d:%0d.%0d required 0 0:0.0",
                     wrap, disp_m, disp_s, disp_cs);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_clear();
        press(0);
        for (int i = 0; i < 6000 && !found; i++) begin
            if (m_live == 1234) found = 1;
            else clk_n(1);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_reach_1234: live=%0d required 1234 within bound", m_live);
        end
        rst = 1; btn_ss = 1; btn_lap = 1; btn_clr = 1;
        clk_n(1);
        checks++;
        if (state !== 2'd0 || running !== 1'b0 || wrap !== 1'b0 ||
            disp_cs !== 7'd0 || disp_s !== 6'd0 || disp_m !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid: state=%0d disp=%0d:%0d.%0d required 0 0:0.0",
                     state, disp_m, disp_s, disp_cs);
        end
        rst = 0;
        clk_n(4);
        checks++;
        if (state !== 2'd0 || disp_cs !== 7'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL rst_held_buttons: state=%0d cs=%0d required 0 0", state, disp_cs);
        end
        btn_ss = 0; btn_lap = 0; btn_clr = 0;
        clk_n(2);
    endtask

    task automatic test_random();
        int ecs, es_, em;
        for (int i = 0; i < 4000; i++) begin
            ecs = m_disp % 100;
            es_ = (m_disp / 100) % 60;
            em  = m_disp / 6000;
            checks++;
            if (int'(state) !== m_st || running !== (m_st == 1 || m_st == 3) ||
                wrap !== m_wrap || int'(disp_cs) !== ecs || int'(disp_s) !== es_ ||
                int'(disp_m) !== em) begin
                failures++;
                $display("FAIL random cyc %0d: st=%0d run=%0b wrap=%0b disp=%0d:%0d.%0d required st=%0d wrap=%0b disp=%0d:%0d.%0d",
                         i, state, running, wrap, disp_m, disp_s, disp_cs,
                         m_st, m_wrap, em, es_, ecs);
            end
            if ($urandom_range(0, 11) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 13) == 0) btn_lap = ~btn_lap;
            if (btn_clr) btn_clr = 0;
            else if ($urandom_range(0, 299) == 0) btn_clr = 1;
            rst = ($urandom_range(0, 999) == 0);
            clk_n(1);
        end
        rst = 0; btn_ss = 0; btn_lap = 0; btn_clr = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        test_reset();
        test_run_pause();
        test_lap();
        test_wrap();
        test_clr_ss();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
